r_ingress_ctrl: RTL

//  Ingress controller of the 1x4 router, directly upstream of the four r_fifo

---
 rtl/r_ingress_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/r_ingress_ctrl.sv
// Ingress controller of the 1x4 router: decodes the packet header, steers header,
// payload and parity bytes into the addressed FIFO, and reports parity/length errors.
module r_ingress_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_PORTS  = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [NUM_PORTS-1:0]  fifo_full,
   input  logic [NUM_PORTS-1:0]  fifo_empty,
   input  logic [NUM_PORTS-1:0]  soft_reset,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [NUM_PORTS-1:0]  write_enb,
   output logic                  lfd_state,
   output logic                  busy,
   output logic                  parity_done,
   output logic                  err,
   output logic                  len_err
);

   localparam int SelW = 2;
   localparam int LenW = DATA_WIDTH - SelW;
   localparam logic [NUM_PORTS-1:0] PortZero = NUM_PORTS'(1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_EMPTY,
      LOAD_HDR,
      LOAD_DATA,
      CHECK_PARITY,
      DROP
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
   logic [DATA_WIDTH-1:0] parity_q, parity_d;
   logic [SelW-1:0]       sel_q, sel_d;
   logic [LenW-1:0]       cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  len_err_q, len_err_d;

   logic                  selFull;
   logic                  selEmpty;
   logic                  selSoft;
   logic                  wrStrobe;

   assign selFull  = fifo_full[sel_q];
   assign selEmpty = fifo_empty[sel_q];
   assign selSoft  = soft_reset[sel_q];

   // A soft reset of the selected FIFO abandons the packet; the rest of it is
   // swallowed in DROP up to and including its parity byte.
   always_comb begin
      state_d   = state_q;
      hdr_d     = hdr_q;
      sel_d     = sel_q;
      parity_d  = parity_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      len_err_d = len_err_q;
      case (state_q)
         IDLE: begin
            if (pkt_valid) begin
               hdr_d     = data_in;
               sel_d     = data_in[SelW-1:0];
               parity_d  = data_in;
               cnt_d     = '0;
               err_d     = 1'b0;
               len_err_d = 1'b0;
               state_d   = fifo_empty[data_in[SelW-1:0]] ? LOAD_HDR : WAIT_EMPTY;
            end
         end
         WAIT_EMPTY: begin
            if (selSoft)       state_d = DROP;
            else if (selEmpty) state_d = LOAD_HDR;
         end
         LOAD_HDR: begin
            if (selSoft)       state_d = DROP;
            else if (!selFull) state_d = LOAD_DATA;
         end
         LOAD_DATA: begin
            if (selSoft) begin
               state_d = DROP;
            end else if (!selFull) begin
               if (pkt_valid) begin
                  parity_d = parity_q ^ data_in;
                  if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               end else begin
                  err_d     = (parity_q != data_in);
                  len_err_d = (cnt_q != hdr_q[DATA_WIDTH-1:SelW]);
                  state_d   = CHECK_PARITY;
               end
            end
         end
         CHECK_PARITY: state_d = IDLE;
         DROP: begin
            if (!pkt_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO-side outputs are decoded from the state so a full or soft-reset FIFO
   // blocks the write in the very cycle it is flagged.
   always_comb begin
      busy        = 1'b0;
      dout        = '0;
      wrStrobe    = 1'b0;
      lfd_state   = 1'b0;
      parity_done = 1'b0;
      case (state_q)
         WAIT_EMPTY: busy = 1'b1;
         LOAD_HDR: begin
            busy      = 1'b1;
            dout      = hdr_q;
            lfd_state = 1'b1;
            wrStrobe  = ~selFull & ~selSoft;
         end
         LOAD_DATA: begin
            busy     = selFull;
            dout     = data_in;
            wrStrobe = ~selFull & ~selSoft;
         end
         CHECK_PARITY: begin
            busy        = 1'b1;
            parity_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign write_enb = wrStrobe ? (PortZero << sel_q) : '0;
   assign err       = err_q;
   assign len_err   = len_err_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         hdr_q     <= '0;
         sel_q     <= '0;
         parity_q  <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hdr_q     <= hdr_d;
         sel_q     <= sel_d;
         parity_q  <= parity_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         len_err_q <= len_err_d;
      end
   end

endmodule
